// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM states
// and the step-counter width helper.
package div_pkg;

   localparam int DEFAULT_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_t;

   // The counter must be able to hold WIDTH itself, hence the extra bit.
   function automatic int step_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int STEP_CNT_WIDTH = step_cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider; the requester drives
// master, the divider sits on slave.
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the
// WIDTH+1-bit partial remainder, keeping the partial remainder on a borrow.
module div_sub_stage
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic             borrow;
   logic [WIDTH:0]   diff;

   // The partial remainder can exceed 2^WIDTH, so the borrow comes from an
   // explicit extra bit rather than from the MSB of the difference.
   always_comb begin
      {borrow, diff} = {1'b0, partial} - {2'b00, divisor};
      q_bit          = ~borrow;
      rem_next       = borrow ? partial : diff;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);

   localparam int            CW        = step_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   div_state_t       state;
   div_state_t       next_state;

   logic [WIDTH:0]   part_rem;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] div_reg;
   logic [CW-1:0]    step_cnt;

   logic [WIDTH-1:0] dvd_in;
   logic [WIDTH-1:0] dvs_in;
   logic [WIDTH-1:0] q_raw;
   logic [WIDTH-1:0] r_raw;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;

   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             dbz_r;

   logic             load_run;
   logic             load_zero;
   logic             do_step;
   logic             last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             q_neg;
   logic             r_neg;

   // The most-negative value maps onto itself, which read unsigned is its magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load_run   = 1'b0;
      load_zero  = 1'b0;
      do_step    = 1'b0;
      last_step  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  load_zero  = 1'b1;
                  next_state = DONE;
               end else begin
                  load_run   = 1'b1;
                  next_state = RUN;
               end
            end
         end
         RUN: begin
            do_step = 1'b1;
            if (step_cnt == LAST_STEP) begin
               last_step  = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd_in = magnitude(bus.dividend);
      dvs_in = magnitude(bus.divisor);
`else
      dvd_in = bus.dividend;
      dvs_in = bus.divisor;
`endif
   end

   // work_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
   assign partial = (part_rem << 1) | {{WIDTH{1'b0}}, work_q[WIDTH-1]};

   div_sub_stage #(
      .WIDTH (WIDTH)
   ) u_sub_stage (
      .partial  (partial),
      .divisor  (div_reg),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_comb begin
      q_raw   = {work_q[WIDTH-2:0], q_bit};
      r_raw   = rem_next[WIDTH-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_final = q_neg ? -q_raw : q_raw;
      r_final = r_neg ? -r_raw : r_raw;
`else
      q_final = q_raw;
      r_final = r_raw;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         part_rem    <= '0;
         work_q      <= '0;
         div_reg     <= '0;
         step_cnt    <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         if (load_run) begin
            part_rem <= '0;
            work_q   <= dvd_in;
            div_reg  <= dvs_in;
            step_cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg    <= bus.dividend[WIDTH-1];
`endif
         end else if (do_step) begin
            part_rem <= rem_next;
            work_q   <= q_raw;
            step_cnt <= step_cnt + 1'b1;
         end

         // Results only move on the edge that enters DONE.
         if (load_zero) begin
            quotient_r  <= '1;
            remainder_r <= bus.dividend;
            dbz_r       <= 1'b1;
         end else if (last_step) begin
            quotient_r  <= q_final;
            remainder_r <= r_final;
            dbz_r       <= 1'b0;
         end
      end
   end

   assign bus.ready       = (state == IDLE);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// against an arithmetic reference model (honours SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider;
   import div_pkg::*;

   localparam int W         = DEFAULT_WIDTH;
   localparam int MAX_EDGES = 40;

   logic clk = 1'b0;
   logic reset;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] held_q = '0;
   logic [W-1:0] held_r = '0;
   logic         held_z = 1'b0;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference result straight from integer division semantics.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      int sa;
      int sb;
      z = (b == '0);
      if (z) begin
         q = '1;
         r = a;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
`else
         sa = int'(a);
         sb = int'(b);
`endif
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
   endfunction

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit hammer);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      int           edges;
      int           ready_hi;
      int           held_bad;
      model(a, b, eq, er, ez);
      edges    = 0;
      ready_hi = 0;
      held_bad = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (!bus.done) begin
            if (bus.ready) ready_hi++;
            if (bus.quotient !== held_q || bus.remainder !== held_r || bus.div_by_zero !== held_z)
               held_bad++;
         end
         if (hammer) begin
            bus.start    = 1'b1;
            bus.dividend = W'(10);
            bus.divisor  = W'(3);
         end else begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
         end
      end while (!bus.done && edges < MAX_EDGES);
      checkOutput("latency", edges, (b == '0) ? 1 : W + 1);
      checkOutput("quotient", bus.quotient, eq);
      checkOutput("remainder", bus.remainder, er);
      checkOutput("div_by_zero", bus.div_by_zero, ez);
      checkOutput("ready_low_busy", ready_hi, 0);
      checkOutput("outputs_held_busy", held_bad, 0);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("done_one_cycle", bus.done, 1'b0);
      checkOutput("ready_after_done", bus.ready, 1'b1);
      checkOutput("quotient_held", bus.quotient, eq);
      checkOutput("remainder_held", bus.remainder, er);
      held_q = eq;
      held_r = er;
      held_z = ez;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready"}, bus.ready, 1'b1);
      checkOutput({tag, "_done"}, bus.done, 1'b0);
      checkOutput({tag, "_quotient"}, bus.quotient, '0);
      checkOutput({tag, "_remainder"}, bus.remainder, '0);
      checkOutput({tag, "_dbz"}, bus.div_by_zero, 1'b0);
      held_q = '0;
      held_r = '0;
      held_z = 1'b0;
   endtask

   task automatic resetMidRun();
      int dones;
      dones = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = W'(100);
      bus.divisor  = W'(7);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkResetState("abort_run");
      repeat (20) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checkOutput("no_done_after_abort", dones, 0);
   endtask

   task automatic resetCorners();
      // Reset wins over a simultaneous start.
      @(negedge clk);
      reset        = 1'b1;
      bus.start    = 1'b1;
      bus.dividend = W'(5);
      bus.divisor  = '0;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      checkResetState("reset_vs_start");
      // Reset while in DONE clears the freshly written results.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("dz_done_before_reset", bus.done, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkResetState("abort_done");
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetState("reset");
      reset = 1'b0;

      applyStimulus(W'(100), W'(7), 1'b0);
      applyStimulus(W'(5), W'(0), 1'b0);
      applyStimulus(W'(4095), W'(1), 1'b1);
      resetMidRun();
      applyStimulus(W'(9), W'(4), 1'b0);
      applyStimulus(W'('hFF9), W'(2), 1'b0);
      applyStimulus(W'('h800), W'('hFFF), 1'b0);
      applyStimulus(W'(0), W'(5), 1'b0);
      applyStimulus(W'(4095), W'(4095), 1'b0);
      applyStimulus(W'(1), W'(4095), 1'b0);
      applyStimulus(W'(4095), W'(0), 1'b0);
      resetCorners();

      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
         endcase
         applyStimulus(a, b, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
